// File: rtl/iec_drive_switch.sv
// Per-slot drive family selector: drains the SD port, holds every core in reset,
// then releases only the newly selected family. Muxes the chosen core onto the sd_* ports.
module iec_drive_switch #(
   parameter int         DRIVES    = 2,
   parameter int         FAMILIES  = 2,
   parameter int         RST_HOLD  = 16,
   parameter logic [7:0] LBA_SHIFT = {4{2'd0}},
   parameter logic [3:0] BLK_FIXED = 4'b0000,
   localparam int        NDR       = (DRIVES < 1) ? 1 : (DRIVES > 4) ? 4 : DRIVES,
   localparam int        TW        = 2
) (
   input  logic                         clk_sys,
   input  logic                         reset_n,
   input  logic [NDR-1:0]               img_mounted,
   input  logic [31:0]                  img_size,
   input  logic [TW-1:0]                img_type,
   input  logic [32*FAMILIES*NDR-1:0]   fam_sd_lba,
   input  logic [6*FAMILIES*NDR-1:0]    fam_sd_blk_cnt,
   input  logic [NDR*FAMILIES-1:0]      fam_sd_rd,
   input  logic [NDR*FAMILIES-1:0]      fam_sd_wr,
   input  logic [8*FAMILIES*NDR-1:0]    fam_sd_din,
   input  logic [NDR-1:0]               sd_ack,
   output logic [32*NDR-1:0]            sd_lba,
   output logic [6*NDR-1:0]             sd_blk_cnt,
   output logic [NDR-1:0]               sd_rd,
   output logic [NDR-1:0]               sd_wr,
   output logic [8*NDR-1:0]             sd_buff_din,
   output logic [NDR*FAMILIES-1:0]      fam_reset,
   output logic [TW*NDR-1:0]            dtype,
   output logic [NDR-1:0]               switching
);

   typedef enum logic [1:0] {ACTIVE, DRAIN, HOLD} slot_state_t;

   for (genvar i = 0; i < NDR; i++) begin : g_slot
      slot_state_t         state, nxt_state;
      logic [TW-1:0]       cur_type, nxt_type, pend, nxt_pend;
      logic [7:0]          cnt, nxt_cnt;
      logic [FAMILIES-1:0] rst_q;
      logic                sw_q;
      logic                mount_ok;
      logic [31:0]         lba_sel;
      logic [5:0]          blk_sel;
      logic [7:0]          din_sel;
      logic                rd_sel, wr_sel;

      assign mount_ok = img_mounted[i] && (img_size != 32'd0) && (32'(img_type) < FAMILIES);

      // Next-state logic; outputs below are registered from these values so they line up with the state
      always_comb begin
         nxt_state = state;
         nxt_type  = cur_type;
         nxt_pend  = pend;
         nxt_cnt   = cnt;
         case (state)
            ACTIVE: begin
               if (mount_ok && img_type != cur_type) begin
                  nxt_pend  = img_type;
                  nxt_state = DRAIN;
               end
            end
            DRAIN: begin
               if (mount_ok)
                  nxt_pend = img_type;
               if (!sd_ack[i]) begin
                  nxt_type  = nxt_pend;
                  nxt_cnt   = 8'(RST_HOLD);
                  nxt_state = HOLD;
               end
            end
            HOLD: begin
               if (mount_ok && img_type != cur_type) begin
                  nxt_type = img_type;
                  nxt_cnt  = 8'(RST_HOLD);
               end else if (cnt <= 8'd1)
                  nxt_state = ACTIVE;
               else
                  nxt_cnt = cnt - 8'd1;
            end
            default: nxt_state = HOLD;
         endcase
      end

      // In DRAIN the outgoing core stays out of reset so it can finish its transfer
      always_ff @(posedge clk_sys or negedge reset_n) begin
         if (!reset_n) begin
            state    <= HOLD;
            cur_type <= '0;
            pend     <= '0;
            cnt      <= 8'(RST_HOLD);
            rst_q    <= '1;
            sw_q     <= 1'b1;
         end else begin
            state    <= nxt_state;
            cur_type <= nxt_type;
            pend     <= nxt_pend;
            cnt      <= nxt_cnt;
            for (int f = 0; f < FAMILIES; f++)
               rst_q[f] <= !((nxt_state != HOLD) && (nxt_type == TW'(f)));
            sw_q     <= (nxt_state != ACTIVE);
         end
      end

      always_comb begin
         lba_sel = '0;
         blk_sel = '0;
         din_sel = '0;
         rd_sel  = 1'b0;
         wr_sel  = 1'b0;
         for (int f = 0; f < FAMILIES; f++) begin
            if (cur_type == TW'(f)) begin
               lba_sel = fam_sd_lba[(i*FAMILIES+f)*32 +: 32] << LBA_SHIFT[2*f +: 2];
               blk_sel = BLK_FIXED[f] ? 6'd1 : fam_sd_blk_cnt[(i*FAMILIES+f)*6 +: 6];
               din_sel = fam_sd_din[(i*FAMILIES+f)*8 +: 8];
               rd_sel  = fam_sd_rd[i*FAMILIES+f];
               wr_sel  = fam_sd_wr[i*FAMILIES+f];
            end
         end
      end

      assign sd_lba[32*i +: 32]              = lba_sel;
      assign sd_blk_cnt[6*i +: 6]            = blk_sel;
      assign sd_buff_din[8*i +: 8]           = din_sel;
      assign sd_rd[i]                        = rd_sel && (state == ACTIVE);
      assign sd_wr[i]                        = wr_sel && (state == ACTIVE);
      assign fam_reset[i*FAMILIES +: FAMILIES] = rst_q;
      assign dtype[TW*i +: TW]               = cur_type;
      assign switching[i]                    = sw_q;
   end

endmodule
